// File: rtl/axis_to_axi4_burst_pkg.sv
// Shared types, AXI constants and the burst-length helper for the stream-to-AXI4 burst writer.
package axis_to_axi4_burst_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AW   = 3'd1,
    ST_W    = 3'd2,
    ST_B    = 3'd3,
    ST_DROP = 3'd4
  } state_e;

  localparam int          AXI_MAX_BEATS  = 256;
  localparam int          AXI_4K         = 4096;
  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;

  // Largest burst that fits the remaining packet, the AXI length limit and the current 4 KB page.
  function automatic logic [8:0] burst_len(input logic [11:0]  addr_lo,
                                           input logic [31:0]  beats_left,
                                           input int unsigned  log2_bytes);
    logic [12:0] room_b;
    logic [12:0] room_beats;
    logic [31:0] lim;
    room_b     = 13'(AXI_4K) - {1'b0, addr_lo};
    room_beats = room_b >> log2_bytes;
    lim        = beats_left;
    if (lim > 32'(AXI_MAX_BEATS)) lim = 32'(AXI_MAX_BEATS);
    if (lim > 32'(room_beats))    lim = 32'(room_beats);
    return 9'(lim);
  endfunction

endpackage

// File: rtl/axi4_if.sv
// Full AXI4 memory-mapped bundle with master and slave views.
interface axi4_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 1
);
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awlock;
  logic [3:0]              awcache;
  logic [2:0]              awprot;
  logic [3:0]              awqos;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;
  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arlock;
  logic [3:0]              arcache;
  logic [2:0]              arprot;
  logic [3:0]              arqos;
  logic                    arvalid;
  logic                    arready;
  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );
  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi4_stream_if.sv
// AXI4-Stream bundle; the writer consumes it through the slave modport.
interface axi4_stream_if #(
  parameter int DATA_WIDTH = 64
);
  logic                    tvalid;
  logic                    tready;
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic                    tlast;
  logic                    tuser;
  logic                    tid;
  logic                    tdest;

  modport master (output tvalid, tdata, tkeep, tlast, tuser, tid, tdest, input tready);
  modport slave  (input tvalid, tdata, tkeep, tlast, tuser, tid, tdest, output tready);
endinterface

// File: rtl/axis_to_axi4_burst.sv
// Write-only DMA: stores one stream packet at a time to memory as 4 KB-safe INCR bursts,
// with one burst outstanding and the W channel passed straight through from the stream.
module axis_to_axi4_burst
  import axis_to_axi4_burst_pkg::*;
#(
  parameter int DATA_WIDTH     = 64,
  parameter int ADDR_WIDTH     = 32,
  parameter int MAX_PKT_SIZE_B = 9600,
  parameter int ID_WIDTH       = 1
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [$clog2(MAX_PKT_SIZE_B+1)-1:0]   pkt_size_i,
  input  logic [ADDR_WIDTH-1:0]                 addr_i,
  axi4_stream_if.slave                          pkt_i,
  axi4_if.master                                burst_o
);

  localparam int BYTES  = DATA_WIDTH / 8;
  localparam int LOG2B  = $clog2(BYTES);
  localparam int SIZE_W = $clog2(MAX_PKT_SIZE_B + 1);
  localparam int BL_W   = (SIZE_W > 9) ? SIZE_W : 9;
  localparam int REM_W  = (LOG2B > 0) ? LOG2B : 1;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [BL_W-1:0]       beats_left_q, beats_left_d;
  logic [8:0]            len_q, len_d;
  logic [8:0]            beat_cnt_q, beat_cnt_d;
  logic [REM_W-1:0]      rem_q, rem_d;
  logic                  awvalid_q, awvalid_d;

  logic [SIZE_W:0]       size_round;
  logic [BL_W-1:0]       beats_total;
  logic [BL_W-1:0]       beats_next;
  logic [ADDR_WIDTH-1:0] addr_next;
  logic                  last_in_burst;
  logic                  last_in_pkt;
  logic                  w_fire;
  logic [BYTES-1:0]      strb_last;

  assign size_round    = {1'b0, pkt_size_i} + (SIZE_W+1)'(BYTES - 1);
  assign beats_total   = BL_W'(size_round >> LOG2B);
  assign addr_next     = addr_q + (ADDR_WIDTH'(len_q) << LOG2B);
  assign beats_next    = beats_left_q - BL_W'(len_q);
  assign last_in_burst = (beat_cnt_q == (len_q - 9'd1));
  // beats_left still counts the current burst until its B arrives.
  assign last_in_pkt   = last_in_burst && (beats_left_q == BL_W'(len_q));
  assign w_fire        = (state_q == ST_W) && pkt_i.tvalid && burst_o.wready;
  assign strb_last     = (BYTES'(1) << rem_q) - BYTES'(1);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    beats_left_d = beats_left_q;
    len_d        = len_q;
    beat_cnt_d   = beat_cnt_q;
    rem_d        = rem_q;
    awvalid_d    = awvalid_q;
    case (state_q)
      ST_IDLE: begin
        if (pkt_i.tvalid) begin
          addr_d       = addr_i;
          beats_left_d = beats_total;
          rem_d        = REM_W'(pkt_size_i & SIZE_W'(BYTES - 1));
          beat_cnt_d   = '0;
          if (pkt_size_i == '0) begin
            state_d = ST_DROP;
          end else begin
            len_d     = burst_len(addr_i[11:0], 32'(beats_total), LOG2B);
            state_d   = ST_AW;
            awvalid_d = 1'b1;
          end
        end
      end
      ST_AW: begin
        if (burst_o.awready) begin
          awvalid_d = 1'b0;
          state_d   = ST_W;
        end
      end
      ST_W: begin
        if (w_fire) begin
          if (last_in_burst) begin
            beat_cnt_d = '0;
            state_d    = ST_B;
          end else begin
            beat_cnt_d = beat_cnt_q + 9'd1;
          end
        end
      end
      ST_B: begin
        if (burst_o.bvalid) begin
          addr_d       = addr_next;
          beats_left_d = beats_next;
          if (beats_next != '0) begin
            len_d     = burst_len(addr_next[11:0], 32'(beats_next), LOG2B);
            state_d   = ST_AW;
            awvalid_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DROP: begin
        if (pkt_i.tvalid && pkt_i.tlast) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      beats_left_q <= '0;
      len_q        <= '0;
      beat_cnt_q   <= '0;
      rem_q        <= '0;
      awvalid_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      beats_left_q <= beats_left_d;
      len_q        <= len_d;
      beat_cnt_q   <= beat_cnt_d;
      rem_q        <= rem_d;
      awvalid_q    <= awvalid_d;
    end
  end

  assign pkt_i.tready    = (state_q == ST_DROP) || ((state_q == ST_W) && burst_o.wready);

  assign burst_o.awid    = ID_WIDTH'(0);
  assign burst_o.awaddr  = addr_q;
  assign burst_o.awlen   = 8'(len_q - 9'd1);
  assign burst_o.awsize  = 3'(LOG2B);
  assign burst_o.awburst = AXI_BURST_INCR;
  assign burst_o.awlock  = 1'b0;
  assign burst_o.awcache = 4'd0;
  assign burst_o.awprot  = 3'd0;
  assign burst_o.awqos   = 4'd0;
  assign burst_o.awvalid = awvalid_q;

  assign burst_o.wvalid  = (state_q == ST_W) && pkt_i.tvalid;
  assign burst_o.wdata   = pkt_i.tdata;
  assign burst_o.wlast   = (state_q == ST_W) && last_in_burst;
  assign burst_o.wstrb   = (last_in_pkt && (rem_q != '0)) ? strb_last : '1;
  assign burst_o.bready  = (state_q == ST_B);

  // Read side is never used.
  assign burst_o.arid    = ID_WIDTH'(0);
  assign burst_o.araddr  = '0;
  assign burst_o.arlen   = 8'd0;
  assign burst_o.arsize  = 3'd0;
  assign burst_o.arburst = AXI_BURST_INCR;
  assign burst_o.arlock  = 1'b0;
  assign burst_o.arcache = 4'd0;
  assign burst_o.arprot  = 3'd0;
  assign burst_o.arqos   = 4'd0;
  assign burst_o.arvalid = 1'b0;
  assign burst_o.rready  = 1'b1;

  logic unused_inputs;
  assign unused_inputs = ^{pkt_i.tkeep, pkt_i.tuser, pkt_i.tid, pkt_i.tdest,
                           burst_o.bid, burst_o.bresp, burst_o.arready,
                           burst_o.rid, burst_o.rdata, burst_o.rresp,
                           burst_o.rlast, burst_o.rvalid};

endmodule

// File: tb/tb_axis_to_axi4_burst.sv
// Directed bench for axis_to_axi4_burst: table of packets against a bus-level memory model.
module tb_axis_to_axi4_burst;

  localparam int DW   = 64;
  localparam int AW   = 32;
  localparam int MAXB = 9600;
  localparam int IDW  = 1;
  localparam int SW   = $clog2(MAXB + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic [SW-1:0] pkt_size;
  logic [AW-1:0] addr;

  axi4_stream_if #(.DATA_WIDTH(DW)) s_if ();
  axi4_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IDW)) m_if ();

  axis_to_axi4_burst #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_PKT_SIZE_B(MAXB), .ID_WIDTH(IDW)
  ) dut (
    .clk_i(clk), .rst_i(rst_n), .pkt_size_i(pkt_size), .addr_i(addr),
    .pkt_i(s_if), .burst_o(m_if)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    int          size;
    int unsigned base;
    int          nbeats;
    bit          rnd;
    int          exp_naw;
    int unsigned exp_aw0_addr;
    int          exp_aw0_len;
    int unsigned exp_awl_addr;
    int          exp_awl_len;
    int          exp_wbeats;
    int          exp_last_strb;
  } vec_t;

  // Memory-side model state
  bit               rnd_slave;
  int unsigned      aw_addr_q[$];
  int               aw_len_q[$];
  int               aw_first_cyc;
  int               w_bidx, w_beat, w_total, pending_b;
  int               data_err, wlast_err, strb_err, proto_err, wv_err;
  int               last_strb;
  int unsigned      cur_base;
  int               cur_size;
  logic [7:0]       mem [int unsigned];

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_model();
    aw_addr_q.delete();
    aw_len_q.delete();
    mem.delete();
    aw_first_cyc = -1;
    w_bidx = 0; w_beat = 0; w_total = 0; pending_b = 0;
    data_err = 0; wlast_err = 0; strb_err = 0; proto_err = 0; wv_err = 0;
    last_strb = 0;
  endtask

  initial begin
    int unsigned ba;
    int          tot_beats;
    logic [7:0]  exp_strb;
    logic [7:0]  exp_byte;
    m_if.awready = 1'b0; m_if.wready = 1'b0; m_if.bvalid = 1'b0;
    m_if.bid = '0; m_if.bresp = 2'b00; m_if.arready = 1'b0;
    m_if.rid = '0; m_if.rdata = '0; m_if.rresp = 2'b00; m_if.rlast = 1'b0; m_if.rvalid = 1'b0;
    forever begin
      @(negedge clk);
      m_if.awready = rnd_slave ? ($urandom_range(0, 1) == 1) : 1'b1;
      m_if.wready  = rnd_slave ? ($urandom_range(0, 3) != 0) : 1'b1;
      m_if.bvalid  = (pending_b > 0) && (!rnd_slave || ($urandom_range(0, 1) == 1));
      #4;
      if (rst_n) begin
        if (m_if.awvalid && aw_first_cyc < 0) aw_first_cyc = cyc;
        if (m_if.wvalid && !s_if.tvalid) wv_err++;
        if (m_if.wvalid && (s_if.tready != m_if.wready)) proto_err++;
        if ((m_if.awvalid || m_if.bready) && s_if.tready) proto_err++;
        if (m_if.arvalid || !m_if.rready) proto_err++;
        if (m_if.awvalid && m_if.awready) begin
          aw_addr_q.push_back(m_if.awaddr);
          aw_len_q.push_back(int'(m_if.awlen));
          if (m_if.awsize != 3'd3 || m_if.awburst != 2'b01 || m_if.awid != '0 ||
              m_if.awcache != 4'd0 || m_if.awprot != 3'd0 || m_if.awlock != 1'b0 ||
              m_if.awqos != 4'd0) proto_err++;
        end
        if (m_if.wvalid && m_if.wready) begin
          if (w_bidx >= aw_addr_q.size()) begin
            proto_err++;
          end else begin
            ba        = aw_addr_q[w_bidx] + 32'(w_beat * 8);
            tot_beats = (cur_size + 7) / 8;
            if (w_total == tot_beats - 1 && (cur_size % 8) != 0)
              exp_strb = 8'((1 << (cur_size % 8)) - 1);
            else
              exp_strb = 8'hFF;
            if (m_if.wstrb != exp_strb) strb_err++;
            last_strb = int'(m_if.wstrb);
            for (int k = 0; k < 8; k++) begin
              if (m_if.wstrb[k]) begin
                exp_byte = 8'((ba + 32'(k) - cur_base) % 256);
                if (m_if.wdata[8*k +: 8] != exp_byte) data_err++;
                mem[ba + 32'(k)] = m_if.wdata[8*k +: 8];
              end
            end
            if (m_if.wlast != (w_beat == aw_len_q[w_bidx])) wlast_err++;
            if (w_beat == aw_len_q[w_bidx]) begin
              w_bidx++;
              w_beat = 0;
              pending_b++;
            end else begin
              w_beat++;
            end
          end
          w_total++;
        end
        if (m_if.bvalid && m_if.bready) pending_b--;
      end
    end
  end

  task automatic send_pkt(input int size, input int unsigned base, input int nbeats, input bit rnd,
                          input int stop_after, output int sent, output int tv_cyc);
    int budget;
    sent   = 0;
    tv_cyc = -1;
    @(negedge clk);
    pkt_size = SW'(size);
    addr     = base;
    for (int b = 0; b < nbeats && b < stop_after; b++) begin
      if (rnd) begin
        repeat ($urandom_range(0, 2)) begin
          s_if.tvalid = 1'b0;
          @(negedge clk);
        end
      end
      s_if.tvalid = 1'b1;
      s_if.tlast  = (b == nbeats - 1);
      for (int k = 0; k < 8; k++) s_if.tdata[8*k +: 8] = 8'((b * 8 + k) % 256);
      if (tv_cyc < 0) tv_cyc = cyc;
      budget = 0;
      while (1) begin
        #4;
        if (s_if.tready) break;
        @(negedge clk);
        budget++;
        if (budget > 2000) begin
          n_cmp++;
          n_bad++;
          $display("FAIL src_timeout: tready stayed 0 for beat %0d, required 1 within 2000 cycles", b);
          s_if.tvalid = 1'b0;
          return;
        end
      end
      sent++;
      @(negedge clk);
    end
    if (stop_after >= nbeats) begin
      s_if.tvalid = 1'b0;
      s_if.tlast  = 1'b0;
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      #2;
      if (!m_if.bready && !m_if.awvalid && pending_b == 0 && w_bidx == aw_addr_q.size()) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v [8];
    int   sent, tvc, err, lsum;
    bit   ok;

    v[0] = '{2049, 32'h000FB100, 257,  1'b0, 2, 32'h000FB100, 255, 32'h000FB900, 0,   257,  8'h01};
    v[1] = '{16,   32'h0000FFF8, 2,    1'b0, 2, 32'h0000FFF8, 0,   32'h00010000, 0,   2,    8'hFF};
    v[2] = '{9600, 32'h00000000, 1200, 1'b0, 5, 32'h00000000, 255, 32'h00002000, 175, 1200, 8'hFF};
    v[3] = '{2049, 32'h000FB100, 257,  1'b1, 2, 32'h000FB100, 255, 32'h000FB900, 0,   257,  8'h01};
    v[4] = '{0,    32'h00000400, 3,    1'b0, 0, 32'h0,        0,   32'h0,        0,   0,    8'h00};
    v[5] = '{13,   32'h00002FF8, 2,    1'b0, 2, 32'h00002FF8, 0,   32'h00003000, 0,   2,    8'h1F};
    v[6] = '{100,  32'h00000FC0, 13,   1'b1, 2, 32'h00000FC0, 7,   32'h00001000, 4,   13,   8'h0F};
    v[7] = '{8,    32'h00000100, 1,    1'b1, 1, 32'h00000100, 0,   32'h00000100, 0,   1,    8'hFF};

    rst_n = 1'b0;
    rnd_slave = 1'b0;
    pkt_size = '0;
    addr = '0;
    s_if.tvalid = 1'b1; s_if.tdata = '0; s_if.tkeep = '1; s_if.tlast = 1'b0;
    s_if.tuser = 1'b0; s_if.tid = 1'b0; s_if.tdest = 1'b0;
    clear_model();

    repeat (3) @(posedge clk);
    #1;
    check("rst_awvalid", m_if.awvalid, 0);
    check("rst_wvalid",  m_if.wvalid,  0);
    check("rst_wlast",   m_if.wlast,   0);
    check("rst_bready",  m_if.bready,  0);
    check("rst_tready",  s_if.tready,  0);
    check("rst_arvalid", m_if.arvalid, 0);
    check("rst_rready",  m_if.rready,  1);
    s_if.tvalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      clear_model();
      cur_base  = v[i].base;
      cur_size  = v[i].size;
      rnd_slave = v[i].rnd;
      send_pkt(v[i].size, v[i].base, v[i].nbeats, v[i].rnd, v[i].nbeats, sent, tvc);
      wait_idle(ok);
      check($sformatf("v%0d_idle_reached", i), ok, 1);
      check($sformatf("v%0d_src_beats", i), sent, v[i].nbeats);
      check($sformatf("v%0d_aw_count", i), aw_addr_q.size(), v[i].exp_naw);
      if (aw_addr_q.size() > 0 && v[i].exp_naw > 0) begin
        check($sformatf("v%0d_aw0_addr", i), aw_addr_q[0], v[i].exp_aw0_addr);
        check($sformatf("v%0d_aw0_len", i), aw_len_q[0], v[i].exp_aw0_len);
        check($sformatf("v%0d_awlast_addr", i), aw_addr_q[aw_addr_q.size()-1], v[i].exp_awl_addr);
        check($sformatf("v%0d_awlast_len", i), aw_len_q[aw_len_q.size()-1], v[i].exp_awl_len);
        check($sformatf("v%0d_aw_latency", i), aw_first_cyc - tvc, 1);
        lsum = 0;
        foreach (aw_len_q[j]) lsum += aw_len_q[j] + 1;
        check($sformatf("v%0d_aw_len_sum", i), lsum, v[i].exp_wbeats);
      end
      check($sformatf("v%0d_w_beats", i), w_total, v[i].exp_wbeats);
      if (v[i].exp_wbeats > 0)
        check($sformatf("v%0d_last_wstrb", i), last_strb, v[i].exp_last_strb);
      check($sformatf("v%0d_data_err", i), data_err, 0);
      check($sformatf("v%0d_wlast_err", i), wlast_err, 0);
      check($sformatf("v%0d_wstrb_err", i), strb_err, 0);
      check($sformatf("v%0d_proto_err", i), proto_err, 0);
      check($sformatf("v%0d_wvalid_wo_tvalid", i), wv_err, 0);
      check($sformatf("v%0d_idle_tready", i), s_if.tready, 0);
      if (i == 2 && aw_addr_q.size() == 5) begin
        check("v2_aw1_addr", aw_addr_q[1], 32'h800);
        check("v2_aw2_addr", aw_addr_q[2], 32'h1000);
        check("v2_aw3_addr", aw_addr_q[3], 32'h1800);
      end
      if (i == 0) begin
        err = 0;
        for (int b = 0; b < 2049; b++) begin
          if (!mem.exists(v[i].base + 32'(b))) err++;
          else if (mem[v[i].base + 32'(b)] != 8'(b % 256)) err++;
        end
        check("v0_mem_content", err, 0);
        check("v0_mem_tail_untouched", mem.exists(v[i].base + 32'd2049), 0);
      end
    end

    // Reset in the middle of a W burst, then a short packet must still go through.
    @(posedge clk);
    #1;
    clear_model();
    cur_base  = 32'h000FB100;
    cur_size  = 2049;
    rnd_slave = 1'b0;
    send_pkt(2049, 32'h000FB100, 257, 1'b0, 10, sent, tvc);
    check("rstw_src_beats", sent, 10);
    #1;
    check("rstw_pre_wvalid", m_if.wvalid, 1);
    rst_n = 1'b0;
    #1;
    check("rstw_awvalid", m_if.awvalid, 0);
    check("rstw_wvalid",  m_if.wvalid,  0);
    check("rstw_bready",  m_if.bready,  0);
    check("rstw_tready",  s_if.tready,  0);
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    @(posedge clk);
    #1;
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    cur_base = 32'h100;
    cur_size = 8;
    send_pkt(8, 32'h100, 1, 1'b0, 1, sent, tvc);
    wait_idle(ok);
    check("post_idle_reached", ok, 1);
    check("post_aw_count", aw_addr_q.size(), 1);
    if (aw_addr_q.size() > 0) begin
      check("post_aw_addr", aw_addr_q[0], 32'h100);
      check("post_aw_len", aw_len_q[0], 0);
      check("post_aw_latency", aw_first_cyc - tvc, 1);
    end
    check("post_w_beats", w_total, 1);
    check("post_last_wstrb", last_strb, 8'hFF);
    check("post_data_err", data_err, 0);
    check("post_wlast_err", wlast_err, 0);
    check("post_proto_err", proto_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
